// File: rtl/mcu_spi_select.sv
// rtl/mcu_spi_select.sv - N-way MCU SPI source selector with debounce, guard cycle, lock and idle revert
// Switching happens only between transactions; the decision uses synchronised csn and the guard cycle hides the late view.
module mcu_spi_select #(
    parameter int N_SRC        = 2,
    parameter int DEFAULT_SRC  = 0,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE     = 4,
    parameter int STICKY       = 1,
    parameter int IDLE_TIMEOUT = 32000000,
    localparam int AW          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk32,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src_sclk,
    input  logic [N_SRC-1:0] src_csn,
    input  logic [N_SRC-1:0] src_mosi,
    input  logic             lock,
    output logic             mcu_sclk,
    output logic             mcu_csn,
    output logic             mcu_mosi,
    output logic [AW-1:0]    active_src,
    output logic             switched
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GUARD} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    active_q, active_d;
    logic             switched_q, switched_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [DW-1:0]    cnt_q [N_SRC];
    logic [N_SRC-1:0] cs_s;
    logic [N_SRC-1:0] qual;
    logic [AW-1:0]    pick;
    logic             any_qual;
    logic             cs_act;
    logic             idle_hit;
    logic             not_default;

    assign cs_s = sync_q[SYNC_STAGES-1];

    // Synchronisers preset high so no source looks selected out of reset.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
        end else begin
            sync_q[0] <= src_csn;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (cs_s[i])
                    cnt_q[i] <= '0;
                else if (cnt_q[i] != DW'(DEBOUNCE))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        qual = '0;
        pick = '0;
        for (int i = 0; i < N_SRC; i++)
            qual[i] = (cnt_q[i] == DW'(DEBOUNCE)) && (AW'(i) != active_q);
        // Descending scan so the lowest qualifying index wins.
        for (int i = N_SRC - 1; i >= 0; i--)
            if (qual[i]) pick = AW'(i);
    end

    assign any_qual    = |qual;
    assign cs_act      = cs_s[active_q];
    assign idle_hit    = (idle_q == TW'(IDLE_TIMEOUT));
    assign not_default = (active_q != AW'(DEFAULT_SRC));

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        switched_d = 1'b0;
        idle_d     = idle_q;
        case (state_q)
            S_IDLE: begin
                if (!lock && any_qual) begin
                    state_d    = S_GUARD;
                    active_d   = pick;
                    switched_d = 1'b1;
                end else if (STICKY == 0 && !lock && not_default && idle_hit) begin
                    state_d    = S_GUARD;
                    active_d   = AW'(DEFAULT_SRC);
                    switched_d = 1'b1;
                end else if (!cs_act) begin
                    state_d = S_BUSY;
                end
                if (lock || switched_d)
                    idle_d = '0;
                else if (cs_act && not_default && !idle_hit)
                    idle_d = idle_q + 1'b1;
            end
            S_BUSY: begin
                idle_d = '0;
                if (cs_act) state_d = S_IDLE;
            end
            S_GUARD: begin
                idle_d  = '0;
                state_d = cs_act ? S_IDLE : S_BUSY;
            end
            default: begin
                idle_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            active_q   <= AW'(DEFAULT_SRC);
            switched_q <= 1'b0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            switched_q <= switched_d;
            idle_q     <= idle_d;
        end
    end

    assign mcu_sclk   = src_sclk[active_q];
    assign mcu_mosi   = src_mosi[active_q];
    assign mcu_csn    = (state_q == S_GUARD) | src_csn[active_q];
    assign active_src = active_q;
    assign switched   = switched_q;

endmodule

// File: tb/tb_mcu_spi_select.sv
// tb/tb_mcu_spi_select.sv - scoreboard bench for mcu_spi_select with a cycle reference model
module tb_mcu_spi_select;

    localparam int N   = 4;
    localparam int SS  = 2;
    localparam int D   = 4;
    localparam int TO  = 100;
    localparam int DEF = 0;

    logic         clk32 = 1'b0;
    logic         reset_n;
    logic [N-1:0] src_sclk, src_csn, src_mosi;
    logic         lock;
    logic         mcu_sclk, mcu_csn, mcu_mosi;
    logic [1:0]   active_src;
    logic         switched;

    mcu_spi_select #(
        .N_SRC(N), .DEFAULT_SRC(DEF), .SYNC_STAGES(SS), .DEBOUNCE(D),
        .STICKY(0), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk32(clk32), .reset_n(reset_n), .src_sclk(src_sclk), .src_csn(src_csn),
        .src_mosi(src_mosi), .lock(lock), .mcu_sclk(mcu_sclk), .mcu_csn(mcu_csn),
        .mcu_mosi(mcu_mosi), .active_src(active_src), .switched(switched)
    );

    always #5 clk32 = ~clk32;

    int checks = 0;
    int errors = 0;
    int sw_seen = 0;

    logic [N-1:0] v_csn, v_sclk, v_mosi;
    logic         v_lock, v_rst;

    // Reference model: raw csn history stands in for the synchroniser, a window
    // of past synchronised values stands in for the debounce counters.
    logic [N-1:0] raw_hist[$];
    logic [N-1:0] cs_hist[$];
    int m_act, m_phase, m_idle;  // phase: 0 idle, 1 in transaction, 2 guard
    bit m_sw;

    logic [5:0] exp_q[$];
    logic [5:0] mon_e, mon_a;

    task automatic model_reset();
        raw_hist.delete();
        cs_hist.delete();
        repeat (SS) raw_hist.push_back('1);
        repeat (D) cs_hist.push_back('1);
        m_act = DEF; m_phase = 0; m_idle = 0; m_sw = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] cs;
        int lowest, n_act, n_phase, n_idle;
        bit n_sw, low_all, cs_act;
        cs = raw_hist[0];
        cs_act = cs[m_act];
        lowest = -1;
        for (int i = 0; i < N; i++) begin
            low_all = 1;
            foreach (cs_hist[k]) if (cs_hist[k][i]) low_all = 0;
            if (i != m_act && low_all && lowest < 0) lowest = i;
        end
        n_act = m_act; n_phase = m_phase; n_idle = m_idle; n_sw = 0;
        if (m_phase == 0) begin
            if (!v_lock && lowest >= 0) begin
                n_act = lowest; n_phase = 2; n_sw = 1;
            end else if (!v_lock && m_act != DEF && m_idle == TO) begin
                n_act = DEF; n_phase = 2; n_sw = 1;
            end else if (!cs_act) begin
                n_phase = 1;
            end
            if (v_lock || n_sw) n_idle = 0;
            else if (cs_act && m_act != DEF && m_idle < TO) n_idle = m_idle + 1;
        end else if (m_phase == 1) begin
            n_idle = 0;
            if (cs_act) n_phase = 0;
        end else begin
            n_idle = 0;
            n_phase = cs_act ? 0 : 1;
        end
        cs_hist.push_back(cs);
        void'(cs_hist.pop_front());
        raw_hist.push_back(v_csn);
        void'(raw_hist.pop_front());
        m_act = n_act; m_phase = n_phase; m_idle = n_idle; m_sw = n_sw;
    endtask

    task automatic step();
        logic [5:0] ex;
        @(negedge clk32);
        v_sclk = N'($urandom);
        v_mosi = N'($urandom);
        reset_n  = v_rst;
        src_csn  = v_csn;
        src_sclk = v_sclk;
        src_mosi = v_mosi;
        lock     = v_lock;
        if (!v_rst) model_reset();
        ex = {2'(m_act), m_sw, (m_phase == 2) ? 1'b1 : v_csn[m_act], v_sclk[m_act], v_mosi[m_act]};
        exp_q.push_back(ex);
        if (v_rst) model_step();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented output set against the queued expectation.
    initial begin
        forever begin
            @(negedge clk32);
            #2;
            if (switched === 1'b1) sw_seen++;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {active_src, switched, mcu_csn, mcu_sclk, mcu_mosi};
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL outputs at %0t: got act=%0d sw=%b csn=%b sclk=%b mosi=%b expected act=%0d sw=%b csn=%b sclk=%b mosi=%b",
                             $time, mon_a[5:4], mon_a[3], mon_a[2], mon_a[1], mon_a[0],
                             mon_e[5:4], mon_e[3], mon_e[2], mon_e[1], mon_e[0]);
                end
            end
        end
    end

    int sw0;
    int rem[N];

    initial begin
        reset_n = 1'b1; src_csn = '1; src_sclk = '0; src_mosi = '0; lock = 1'b0;
        v_csn = '1; v_sclk = '0; v_mosi = '0; v_lock = 1'b0; v_rst = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;

        run(3);
        v_rst = 1'b1;
        run(2);
        #3;
        chk("reset_active_src", active_src, 0);
        chk("reset_switched", switched, 0);
        chk("reset_mcu_csn", mcu_csn, 1);
        step(); #3;
        chk("sclk_follows_src0", mcu_sclk, v_sclk[0]);

        sw0 = sw_seen;
        v_csn[1] = 1'b0; run(3);
        v_csn[1] = 1'b1; run(10);
        #3;
        chk("short_low_no_switch", sw_seen - sw0, 0);
        v_csn[1] = 1'b0; run(10);
        #3;
        chk("debounced_switch_count", sw_seen - sw0, 1);
        chk("debounced_switch_src", active_src, 1);
        chk("follow_src1_csn", mcu_csn, 0);

        v_csn[1] = 1'b1; run(115);
        #3;
        chk("timeout_revert_src", active_src, 0);

        v_csn[0] = 1'b0; run(4);
        sw0 = sw_seen;
        v_csn[1] = 1'b0; run(20);
        #3;
        chk("busy_blocks_switch", sw_seen - sw0, 0);
        v_csn[0] = 1'b1; run(6);
        #3;
        chk("switch_after_busy", active_src, 1);
        v_csn[1] = 1'b1; run(6);

        v_csn[2] = 1'b0; v_csn[3] = 1'b0; run(10);
        #3;
        chk("lowest_index_wins", active_src, 2);
        v_csn[2] = 1'b1; v_csn[3] = 1'b1; run(6);

        v_lock = 1'b1;
        sw0 = sw_seen;
        run(150);
        v_csn[1] = 1'b0; run(12);
        #3;
        chk("lock_no_switch", sw_seen - sw0, 0);
        chk("lock_holds_src", active_src, 2);
        v_csn[1] = 1'b1; v_lock = 1'b0; run(5);

        v_csn[1] = 1'b0; run(10);
        #3;
        chk("busy_on_src1", active_src, 1);
        v_rst = 1'b0; step();
        #3;
        chk("midtx_reset_src", active_src, 0);
        chk("midtx_reset_switched", switched, 0);
        chk("midtx_reset_csn", mcu_csn, v_csn[0]);
        run(2);
        v_csn = '1; v_rst = 1'b1; run(3);

        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 30);
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < N; i++) begin
                    rem[i]--;
                    if (rem[i] <= 0) begin
                        v_csn[i] = ~v_csn[i];
                        rem[i] = v_csn[i] ? $urandom_range(1, (seg % 2) ? 40 : 250)
                                          : $urandom_range(1, 14);
                    end
                end
                if ($urandom_range(0, 299) == 0) v_lock = ~v_lock;
                step();
            end
        end

        v_csn = '1; v_lock = 1'b0;
        run(3);
        #3;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_spi_select.md
Name: mcu_spi_select

Overview:
- N-way selector for the MCU SPI link: routes one of N_SRC candidate MCU ports (on-board BL616, M0S Dock, further docks) onto the single mcu_sclk/mcu_csn/mcu_mosi interface of the core.
- Generalises the fixed two-source, switch-once selection. Adds:
  - debounced chip-select detection;
  - switching only between transactions;
  - a chip-select guard cycle on every switch;
  - a software lock;
  - optional revert to the default source after idle timeout.
- Sits in the board top level, clocked by clk32.

Parameters:
- N_SRC, 2, number of candidate MCU ports (2..8); index 0 = on-board MCU.
- DEFAULT_SRC, 0, source active after reset and target of timeout revert.
- SYNC_STAGES, 2, synchroniser depth on each src_csn (2..3).
- DEBOUNCE, 4, consecutive synchronised-low clk32 cycles of a src_csn needed to qualify that source (1..255).
- STICKY, 1, 1 = never revert after switching; 0 = revert to DEFAULT_SRC after IDLE_TIMEOUT.
- IDLE_TIMEOUT, 32000000, clk32 cycles of active-source csn high before revert (STICKY=0 only); counter width = $clog2(IDLE_TIMEOUT+1).

Ports:
- clk32  input  1  system clock (32 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- src_sclk  input  N_SRC  SPI clock per source.
- src_csn  input  N_SRC  SPI select per source, active low.
- src_mosi  input  N_SRC  MCU-to-FPGA data per source.
- lock  input  1  1 = freeze current selection, no switching or revert.
- mcu_sclk  output  1  selected sclk.
- mcu_csn  output  1  selected csn, forced 1 during guard.
- mcu_mosi  output  1  selected mosi.
- active_src  output  max(1,$clog2(N_SRC))  index of selected source.
- switched  output  1  one-cycle pulse when active_src changes.

Behaviour:
- Reset (async assert, sync deassert of internal state):
  - active_src=DEFAULT_SRC, state=IDLE, switched=0;
  - all debounce counters=0, idle counter=0;
  - synchronisers preset to 1.
- Synchronisation: each src_csn passes through SYNC_STAGES flops → cs_s[i]. sclk and mosi are not synchronised (data path).
- Debounce:
  - cnt[i] increments while cs_s[i]=0, saturating at DEBOUNCE;
  - cnt[i] clears to 0 whenever cs_s[i]=1;
  - qual[i] = (cnt[i]==DEBOUNCE) && (i!=active_src).
- Output mux (combinational from raw inputs):
  - mcu_sclk=src_sclk[active_src], mcu_mosi=src_mosi[active_src];
  - mcu_csn = (state==GUARD) ? 1 : src_csn[active_src].
- FSM:
  - IDLE (cs_s[active]=1):
    - if lock=0 and any qual → GUARD; active_src ← lowest qualifying index; switched=1 for one cycle; idle counter cleared.
    - else if STICKY=0, lock=0, active_src!=DEFAULT_SRC and idle counter reaches IDLE_TIMEOUT → GUARD; active_src ← DEFAULT_SRC; switched=1.
    - else if cs_s[active]=0 → BUSY.
  - BUSY: no switching, idle counter held at 0; → IDLE when cs_s[active]=1.
  - GUARD: exactly one cycle, mcu_csn forced 1; → IDLE if cs_s[new active]=1, else BUSY.
- Idle counter: increments in IDLE while active csn high and active_src!=DEFAULT_SRC, saturating; cleared in BUSY, GUARD, or on lock=1.
- Simultaneous events:
  - multiple qualifying sources → lowest index wins;
  - qualification and timeout in the same cycle → qualification wins;
  - active source going low in the same cycle as another qualifies → switch taken (decision uses cs_s, one cycle late; the guard cycle masks the overlap).
- Qualification of a non-active source does not persist: if its csn rises before the active source goes idle, cnt clears and it must requalify.
- lock=1: active_src, state transitions to GUARD and revert suppressed; IDLE/BUSY tracking continues.
- reset_n low mid-transaction: immediate return to DEFAULT_SRC; outputs follow the raw default source.

Test Plan:
- Reset, N_SRC=2, all csn=1 → active_src=0, switched=0, mcu_csn=1; toggle src_sclk[0] → mcu_sclk follows within the same cycle.
- Hold src_csn[1]=0 for 3 cycles, then 1 (DEBOUNCE=4) → no switch; hold it low for 8 cycles → switched pulses once, active_src=1, mcu_csn=1 for exactly one cycle, then mcu_csn=src_csn[1].
- Active=0 with src_csn[0]=0 (BUSY) while src_csn[1] is held low for 20 cycles → no switch until src_csn[0] rises; switch occurs SYNC_STAGES+1 cycles after that.
- N_SRC=4, src_csn[2] and src_csn[3] qualify in the same cycle → active_src=2.
- STICKY=0, IDLE_TIMEOUT=100, switched to source 1, csn high → revert to 0 after 100 idle cycles; repeat with lock=1 → no revert and no switching.
- Assert reset_n=0 while active_src=1 and mid-transaction → active_src=0 immediately, switched=0.
